x_rsp_sz: RTL and testbench

X_RSP_SZ -- requirements
Module: x_rsp_sz

---
 rtl/x_rsp_sz.sv | 209 ++++++++++++++++++++
 tb/tb_x_rsp_sz.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_rsp_sz.sv
// -----------------------------------------------------------------------------
// x_rsp_sz -- response data-width converter with in-order lane tracking.
//
// Requests pass straight through from master to slave. Each accepted request
// records which lane of the wider bus its address selects, in an in-order
// FIFO. Each slave response pops that lane offset and uses it to either
// extract the addressed DWM slice of a wider slave word (downsize) or place a
// narrower slave word into its lane of a wider master word, zeroing the rest
// (upsize). The response then passes through a single registered output stage.
//
// Parameters
//   AW    request address width
//   DWS   slave-side response data width  (power of 2, >= 8)
//   DWM   master-side response data width (power of 2, >= 8)
//   DEPTH maximum outstanding requests    (power of 2, >= 2)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_vld_i/req_rdy_o     master request handshake, req_adr_i byte address
//   req_vld_o/req_rdy_i     slave request handshake, req_adr_o = req_adr_i
//   rsp_vld_i/rsp_rdy_o     slave response handshake, rsp_dat_i, rsp_err_i
//   rsp_vld_o/rsp_rdy_i     master response handshake, rsp_dat_o, rsp_err_o
//   cnt_o                   outstanding request count, 0..DEPTH
//   unexp_o                 sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module x_rsp_sz #(
  parameter int AW    = 19,
  parameter int DWS   = 64,
  parameter int DWM   = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_vld_i,
  output logic                     req_rdy_o,
  input  logic [AW-1:0]            req_adr_i,
  output logic                     req_vld_o,
  input  logic                     req_rdy_i,
  output logic [AW-1:0]            req_adr_o,
  input  logic                     rsp_vld_i,
  output logic                     rsp_rdy_o,
  input  logic [DWS-1:0]           rsp_dat_i,
  input  logic                     rsp_err_i,
  output logic                     rsp_vld_o,
  input  logic                     rsp_rdy_i,
  output logic [DWM-1:0]           rsp_dat_o,
  output logic                     rsp_err_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     unexp_o
);

  localparam int PW = $clog2(DEPTH);     // FIFO pointer width
  localparam int CW = PW + 1;            // occupancy width, holds 0..DEPTH
  localparam int SB = $clog2(DWS / 8);   // byte-offset bits of a slave word
  localparam int MB = $clog2(DWM / 8);   // byte-offset bits of a master word
  // Lane offset width: log2 of the width ratio, or a single constant bit
  // when both sides match.
  localparam int OW = (DWS > DWM) ? (SB - MB) :
                      (DWS < DWM) ? (MB - SB) : 1;

  // ---------------------------------------------------------------------------
  // Lane offset taken from the request address
  // ---------------------------------------------------------------------------
  logic [OW-1:0] off_req;

  if (DWS > DWM) begin : g_off_dn
    assign off_req = req_adr_i[SB-1:MB];
  end else if (DWS < DWM) begin : g_off_up
    assign off_req = req_adr_i[MB-1:SB];
  end else begin : g_off_eq
    assign off_req = '0;
  end

  // ---------------------------------------------------------------------------
  // Offset FIFO state
  // ---------------------------------------------------------------------------
  logic [OW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty;
  logic          push, pop;

  // Output stage state
  logic           rsp_vld_q, rsp_vld_d;
  logic [DWM-1:0] rsp_dat_q, rsp_dat_d;
  logic           rsp_err_q, rsp_err_d;
  logic           unexp_q, unexp_d;

  logic           rsp_acc;
  logic [OW-1:0]  off_rsp;
  logic [DWM-1:0] dat_fmt;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // Request path: pure pass-through, gated only by FIFO space. A pop in the
  // same cycle never frees room for a push while full.
  // ---------------------------------------------------------------------------
  assign req_adr_o = req_adr_i;
  assign req_vld_o = req_vld_i & ~full;
  assign req_rdy_o = req_rdy_i & ~full;
  assign push      = req_vld_i & req_rdy_o;

  // ---------------------------------------------------------------------------
  // Response accept. The output stage frees up when it is empty or being
  // drained this cycle, which gives one response per cycle at full rate.
  // ---------------------------------------------------------------------------
  assign rsp_rdy_o = ~rsp_vld_q | rsp_rdy_i;
  assign rsp_acc   = rsp_vld_i & rsp_rdy_o;
  // An unexpected response (nothing outstanding) must not pop.
  assign pop       = rsp_acc & ~empty;

  // The offset comes only from entries already stored: an offset being pushed
  // this cycle is never visible to a response in the same cycle.
  assign off_rsp = empty ? '0 : mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Data formatting
  // ---------------------------------------------------------------------------
  if (DWS > DWM) begin : g_dat_dn
    localparam int NL = DWS / DWM;
    logic [DWM-1:0] lanes [NL];
    for (genvar i = 0; i < NL; i++) begin : g_lane
      assign lanes[i] = rsp_dat_i[i*DWM +: DWM];
    end
    assign dat_fmt = lanes[off_rsp];
  end else if (DWS < DWM) begin : g_dat_up
    localparam int NL = DWM / DWS;
    always_comb begin
      // NOTE: every always_comb output gets a default before any branch so no
      // path leaves it unassigned, which would otherwise infer a latch.
      dat_fmt = '0;
      for (int i = 0; i < NL; i++) begin
        if (off_rsp == OW'(i)) dat_fmt[i*DWS +: DWS] = rsp_dat_i;
      end
    end
  end else begin : g_dat_eq
    logic unused_off;
    assign unused_off = ^off_rsp;
    assign dat_fmt    = rsp_dat_i;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rsp_vld_d = rsp_vld_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unexp_d   = unexp_q;

    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (rsp_acc) begin
      rsp_vld_d = 1'b1;
      rsp_dat_d = dat_fmt;
      rsp_err_d = rsp_err_i;
      if (empty) unexp_d = 1'b1;
    end else if (rsp_rdy_i) begin
      rsp_vld_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      unexp_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      unexp_q   <= unexp_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; an entry is only read after
  // it has been written, and the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= off_req;
  end

  assign rsp_vld_o = rsp_vld_q;
  assign rsp_dat_o = rsp_dat_q;
  assign rsp_err_o = rsp_err_q;
  assign cnt_o     = cnt_q;
  assign unexp_o   = unexp_q;

endmodule

// File: tb/tb_x_rsp_sz.sv
// -----------------------------------------------------------------------------
// tb_x_rsp_sz -- self-checking bench for x_rsp_sz.
//
// Instance u_dn (DWS=64, DWM=32, DEPTH=4) runs directed scenarios followed by
// randomized traffic; a queue-based reference model tracks it every cycle.
// Instance u_up (DWS=32, DWM=64) covers lane placement when upsizing.
// -----------------------------------------------------------------------------
module tb_x_rsp_sz;

  localparam int AW    = 19;
  localparam int DWS   = 64;
  localparam int DWM   = 32;
  localparam int DEPTH = 4;
  localparam int MB    = 2;            // log2(DWM/8)
  localparam int NL    = DWS / DWM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- downsize instance signals
  logic           req_vld_i = 0, req_rdy_i = 0, rsp_vld_i = 0, rsp_err_i = 0, rsp_rdy_i = 0;
  logic [AW-1:0]  req_adr_i = '0;
  logic [DWS-1:0] rsp_dat_i = '0;
  logic           req_rdy_o, req_vld_o, rsp_rdy_o, rsp_vld_o, rsp_err_o, unexp_o;
  logic [AW-1:0]  req_adr_o;
  logic [DWM-1:0] rsp_dat_o;
  logic [2:0]     cnt_o;

  // ---------------- upsize instance signals
  logic           up_req_vld_i = 0, up_req_rdy_i = 0, up_rsp_vld_i = 0, up_rsp_err_i = 0, up_rsp_rdy_i = 0;
  logic [AW-1:0]  up_req_adr_i = '0;
  logic [31:0]    up_rsp_dat_i = '0;
  logic           up_req_rdy_o, up_req_vld_o, up_rsp_rdy_o, up_rsp_vld_o, up_rsp_err_o, up_unexp_o;
  logic [AW-1:0]  up_req_adr_o;
  logic [63:0]    up_rsp_dat_o;
  logic [2:0]     up_cnt_o;

  x_rsp_sz #(.AW(AW), .DWS(DWS), .DWM(DWM), .DEPTH(DEPTH)) u_dn (
    .clk(clk), .rst_n(rst_n),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_adr_i(req_adr_i),
    .req_vld_o(req_vld_o), .req_rdy_i(req_rdy_i), .req_adr_o(req_adr_o),
    .rsp_vld_i(rsp_vld_i), .rsp_rdy_o(rsp_rdy_o), .rsp_dat_i(rsp_dat_i), .rsp_err_i(rsp_err_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .cnt_o(cnt_o), .unexp_o(unexp_o)
  );

  x_rsp_sz #(.AW(AW), .DWS(32), .DWM(64), .DEPTH(DEPTH)) u_up (
    .clk(clk), .rst_n(rst_n),
    .req_vld_i(up_req_vld_i), .req_rdy_o(up_req_rdy_o), .req_adr_i(up_req_adr_i),
    .req_vld_o(up_req_vld_o), .req_rdy_i(up_req_rdy_i), .req_adr_o(up_req_adr_o),
    .rsp_vld_i(up_rsp_vld_i), .rsp_rdy_o(up_rsp_rdy_o), .rsp_dat_i(up_rsp_dat_i), .rsp_err_i(up_rsp_err_i),
    .rsp_vld_o(up_rsp_vld_o), .rsp_rdy_i(up_rsp_rdy_i), .rsp_dat_o(up_rsp_dat_o), .rsp_err_o(up_rsp_err_o),
    .cnt_o(up_cnt_o), .unexp_o(up_unexp_o)
  );

  // ---------------- bookkeeping
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (downsize instance)
  int             mq[$];           // lane offsets of outstanding requests, oldest first
  bit             m_vld = 0;
  logic [DWM-1:0] m_dat = '0;
  bit             m_err = 0;
  bit             m_unexp = 0;

  bit             mdl_full, mdl_acc, mdl_push;
  int             mdl_off;
  logic [DWS-1:0] mdl_sh;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_vld = 0; m_dat = '0; m_err = 0; m_unexp = 0;
    end else begin
      mdl_full = (mq.size() == DEPTH);
      mdl_acc  = rsp_vld_i && (!m_vld || rsp_rdy_i);
      mdl_push = req_vld_i && req_rdy_i && !mdl_full;
      if (mdl_acc) begin
        if (mq.size() == 0) begin
          mdl_off = 0;
          m_unexp = 1;
        end else begin
          mdl_off = mq.pop_front();
        end
        mdl_sh = rsp_dat_i >> (mdl_off * DWM);
        m_dat  = mdl_sh[DWM-1:0];
        m_err  = rsp_err_i;
        m_vld  = 1;
      end else if (rsp_rdy_i) begin
        m_vld = 0;
      end
      // Pushed after the pop: a response never sees a same-cycle request.
      if (mdl_push) mq.push_back((int'(req_adr_i) >> MB) % NL);
    end
  end

  // Compare process: inputs are stable at the falling edge.
  bit cmp_full;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp_vld", rsp_vld_o, 0);
      check("rst_cnt", cnt_o, 0);
      check("rst_unexp", unexp_o, 0);
    end else begin
      cmp_full = (mq.size() == DEPTH);
      check("req_rdy_o", req_rdy_o, req_rdy_i && !cmp_full);
      check("req_vld_o", req_vld_o, req_vld_i && !cmp_full);
      check("req_adr_o", req_adr_o, req_adr_i);
      check("rsp_rdy_o", rsp_rdy_o, !m_vld || rsp_rdy_i);
      check("rsp_vld_o", rsp_vld_o, m_vld);
      if (m_vld) begin
        check("rsp_dat_o", rsp_dat_o, m_dat);
        check("rsp_err_o", rsp_err_o, m_err);
      end
      check("cnt_o", cnt_o, mq.size());
      check("unexp_o", unexp_o, m_unexp);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus
  int unsigned p_req, p_rsp, p_rdy;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_vld", rsp_vld_o, 0);
    check("reset_dat", rsp_dat_o, 0);
    check("reset_err", rsp_err_o, 0);
    check("reset_cnt", cnt_o, 0);
    check("reset_unexp", unexp_o, 0);
    rst_n = 1'b1;
    req_rdy_i = 1; rsp_rdy_i = 1;
    #1;
    check("post_reset_req_rdy", req_rdy_o, 1);

    // Downsize lane selection
    req_vld_i = 1; req_adr_i = 19'h4;
    step();
    req_adr_i = 19'h0;
    rsp_vld_i = 1; rsp_dat_i = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    check("dn_hi_vld", rsp_vld_o, 1);
    check("dn_hi_dat", rsp_dat_o, 32'hAAAA_BBBB);
    check("model_hi_dat", m_dat, 32'hAAAA_BBBB);
    req_vld_i = 0;
    step();
    check("dn_lo_dat", rsp_dat_o, 32'hCCCC_DDDD);
    rsp_vld_i = 0;
    step();
    check("dn_idle_vld", rsp_vld_o, 0);
    check("dn_idle_cnt", cnt_o, 0);

    // Full: four requests, no responses
    req_vld_i = 1; req_adr_i = 19'h10;
    repeat (4) step();
    check("full_cnt", cnt_o, 4);
    check("full_req_rdy", req_rdy_o, 0);
    check("full_req_vld", req_vld_o, 0);
    rsp_vld_i = 1; rsp_dat_i = 64'h0123_4567_89AB_CDEF;
    step();
    check("full_pop_no_push_cnt", cnt_o, 3);
    check("full_pop_dat", rsp_dat_o, 32'h89AB_CDEF);
    req_vld_i = 0;
    repeat (3) step();
    rsp_vld_i = 0;
    step();
    check("drain_cnt", cnt_o, 0);
    check("drain_unexp", unexp_o, 0);

    // Back-pressure
    req_vld_i = 1; req_adr_i = 19'h0;
    step();
    req_adr_i = 19'h4;
    step();
    req_vld_i = 0;
    rsp_rdy_i = 0; rsp_vld_i = 1; rsp_dat_i = 64'h1111_2222_3333_4444;
    step();
    rsp_dat_i = 64'h5555_6666_7777_8888;
    for (int i = 0; i < 3; i++) begin
      check("bp_vld", rsp_vld_o, 1);
      check("bp_dat", rsp_dat_o, 32'h3333_4444);
      check("bp_rsp_rdy", rsp_rdy_o, 0);
      check("bp_cnt", cnt_o, 1);
      if (i < 2) step();
    end
    rsp_rdy_i = 1;
    step();
    check("bp_second_vld", rsp_vld_o, 1);
    check("bp_second_dat", rsp_dat_o, 32'h5555_6666);
    check("bp_second_cnt", cnt_o, 0);
    rsp_vld_i = 0;
    step();
    check("bp_done_vld", rsp_vld_o, 0);

    // Unexpected response
    rsp_vld_i = 1; rsp_dat_i = 64'h9999_AAAA_BBBB_CCCC; rsp_err_i = 1;
    step();
    check("unexp_set", unexp_o, 1);
    check("unexp_cnt", cnt_o, 0);
    check("unexp_dat", rsp_dat_o, 32'hBBBB_CCCC);
    check("unexp_err", rsp_err_o, 1);
    rsp_vld_i = 0; rsp_err_i = 0;
    repeat (3) step();
    check("unexp_sticky", unexp_o, 1);
    check("unexp_cnt_hold", cnt_o, 0);

    // Reset mid-operation
    req_vld_i = 1; req_adr_i = 19'h4;
    repeat (2) step();
    rsp_rdy_i = 0; rsp_vld_i = 1; rsp_dat_i = 64'hFEDC_BA98_7654_3210;
    step();
    check("pre_rst_cnt", cnt_o, 2);
    check("pre_rst_vld", rsp_vld_o, 1);
    req_vld_i = 0; rsp_vld_i = 0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_vld", rsp_vld_o, 0);
    check("async_rst_dat", rsp_dat_o, 0);
    check("async_rst_err", rsp_err_o, 0);
    check("async_rst_cnt", cnt_o, 0);
    check("async_rst_unexp", unexp_o, 0);
    check("async_rst_req_rdy", req_rdy_o, 1);
    step();
    rst_n = 1'b1; rsp_rdy_i = 1;
    #1;
    check("release_req_rdy", req_rdy_o, 1);

    // Upsize lane placement
    up_req_rdy_i = 1; up_rsp_rdy_i = 1;
    up_req_vld_i = 1; up_req_adr_i = 19'h4;
    step();
    up_req_vld_i = 0; up_rsp_vld_i = 1; up_rsp_dat_i = 32'h1234_5678;
    step();
    check("up_hi_vld", up_rsp_vld_o, 1);
    check("up_hi_dat", up_rsp_dat_o, 64'h1234_5678_0000_0000);
    check("up_hi_cnt", up_cnt_o, 0);
    up_rsp_vld_i = 0; up_req_vld_i = 1; up_req_adr_i = 19'h8;
    step();
    up_req_vld_i = 0; up_rsp_vld_i = 1; up_rsp_dat_i = 32'hDEAD_BEEF; up_rsp_err_i = 1;
    step();
    check("up_lo_dat", up_rsp_dat_o, 64'h0000_0000_DEAD_BEEF);
    check("up_lo_err", up_rsp_err_o, 1);
    check("up_unexp", up_unexp_o, 0);
    up_rsp_vld_i = 0; up_rsp_err_i = 0;
    step();
    check("up_idle_vld", up_rsp_vld_o, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        p_req = $urandom_range(10, 95);
        p_rsp = $urandom_range(10, 95);
        p_rdy = $urandom_range(10, 100);
      end
      req_vld_i = ($urandom_range(0, 99) < p_req);
      req_rdy_i = ($urandom_range(0, 99) < 85);
      req_adr_i = AW'($urandom);
      rsp_vld_i = ($urandom_range(0, 99) < p_rsp);
      rsp_dat_i = {$urandom, $urandom};
      rsp_err_i = ($urandom_range(0, 7) == 0);
      rsp_rdy_i = ($urandom_range(0, 99) < p_rdy);
      step();
    end

    req_vld_i = 0; rsp_vld_i = 0; rsp_rdy_i = 1;
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
